// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
//   Shared types and constants for the commit-trace capture block.
//   - WORDS_PER_REC : number of 32-bit words each record is serialized into
//   - SEQ_SENT_W    : number of sequence bits carried in the trace word W3
//   - trace_rec_t   : one buffered commit record
//   - ser_state_t   : serializer FSM states
//   - word_idx_t    : index of the word being presented within a record
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int WORDS_PER_REC = 6;
  localparam int SEQ_SENT_W    = 16;

  typedef logic [2:0] word_idx_t;

  localparam word_idx_t LAST_WORD_IDX = word_idx_t'(WORDS_PER_REC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // The record only stores the sequence bits that are ever transmitted,
  // which keeps the struct a fixed size independent of SEQW.
  typedef struct packed {
    logic [63:0]           pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  regwrite;
    logic [63:0]           wdata;
    logic [SEQ_SENT_W-1:0] seq;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
//   Synchronous FIFO of trace_rec_t records.
//   Ports:
//     clk        : clock, rising edge
//     reset      : asynchronous active-low reset (empties the FIFO)
//     i_push     : write i_push_rec this cycle (ignored when full unless a
//                  pop happens in the same cycle)
//     i_push_rec : record to write
//     i_pop      : discard the head record this cycle (ignored when empty)
//     o_head_rec : record at the head of the FIFO
//     o_full     : DEPTH records held
//     o_empty    : no records held
//     o_count    : number of records held
// ---------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  trace_rec_t               i_push_rec,
  input  logic                     i_pop,
  output trace_rec_t               o_head_rec,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the write lands in, so a full
  // FIFO can still take a record when its head leaves on this edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage has no reset so it can map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Extra wrap bit distinguishes full (wrap bits differ) from empty.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_head_rec = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_trace_capture.sv
// ---------------------------------------------------------------------------
// riscv_trace_capture
//   Captures committed instructions of a 64-bit RISC-V core into a FIFO and
//   streams them out as six 32-bit words per record over valid/ready.
//   Records arriving while the FIFO is full are dropped and counted.
//   Parameters:
//     DEPTH : FIFO depth in records (power of 2, >= 2)
//     SEQW  : width of the sequence counter and drop counter
//   Ports:
//     clk, reset      : clock and asynchronous active-low reset
//     commit_*        : core observation inputs, sampled when commit_valid=1
//     out_valid/out_data/out_last/out_ready : trace word stream
//     overflow        : sticky, set when any record was dropped
//     drop_count      : saturating count of dropped records
//     clear_overflow  : synchronous clear of overflow and drop_count
//   Word order: pc[31:0], pc[63:32], instr, {seq[15:0],10'b0,regwrite,rd},
//               wdata[31:0], wdata[63:32] (last).
// ---------------------------------------------------------------------------
module riscv_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [63:0]     commit_pc,
  input  logic [31:0]     commit_instr,
  input  logic [4:0]      commit_rd,
  input  logic            commit_regwrite,
  input  logic [63:0]     commit_wdata,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            overflow,
  output logic [SEQW-1:0] drop_count,
  input  logic            clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ser_state_t            r_state;
  ser_state_t            w_state_next;
  word_idx_t             r_idx;
  word_idx_t             w_idx_next;
  logic [SEQW-1:0]       r_seq;
  logic [SEQW-1:0]       r_drop_count;
  logic                  r_overflow;

  trace_rec_t            w_push_rec;
  trace_rec_t            w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_empty_after_pop;
  logic [SEQ_SENT_W-1:0] w_seq_sent;
  logic [31:0]           w_word;

  // Only the low 16 sequence bits travel with the record.
  generate
    if (SEQW >= SEQ_SENT_W) begin : g_seq_trunc
      assign w_seq_sent = r_seq[SEQ_SENT_W-1:0];
    end else begin : g_seq_ext
      assign w_seq_sent = {{(SEQ_SENT_W-SEQW){1'b0}}, r_seq};
    end
  endgenerate

  assign w_push_rec = '{
    pc:       commit_pc,
    instr:    commit_instr,
    rd:       commit_rd,
    regwrite: commit_regwrite,
    wdata:    commit_wdata,
    seq:      w_seq_sent
  };

  // -------------------------------------------------------------------------
  // Push / pop / drop decisions
  // -------------------------------------------------------------------------
  assign out_valid = (r_state == SEND);
  assign w_hs      = out_valid && out_ready;
  assign w_pop     = w_hs && (r_idx == LAST_WORD_IDX);
  // A record leaving on this edge makes room for the incoming one.
  assign w_push    = commit_valid && (!w_full || w_pop);
  assign w_drop    = commit_valid && w_full && !w_pop;
  // After a pop the FIFO is empty only if it held one record and nothing
  // arrives on the same edge.
  assign w_empty_after_pop = (w_count == CW'(1)) && !w_push;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_rec (w_push_rec),
    .i_pop      (w_pop),
    .o_head_rec (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // -------------------------------------------------------------------------
  // Sequence and drop accounting
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq <= '0;
    end else if (w_push) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      // A drop coinciding with a clear leaves exactly this drop recorded.
      r_overflow <= 1'b1;
      if (clear_overflow) begin
        r_drop_count <= SEQW'(1);
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // -------------------------------------------------------------------------
  // Serializer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_next = SEND;
          w_idx_next   = '0;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (r_idx == LAST_WORD_IDX) begin
            // Next record starts immediately with no idle cycle.
            w_idx_next = '0;
            if (w_empty_after_pop) begin
              w_state_next = IDLE;
            end
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Word mux: driven only by the registered head record and word index, so
  // the stream holds steady while the sink stalls.
  // -------------------------------------------------------------------------
  always_comb begin
    w_word = '0;
    case (r_idx)
      3'd0:    w_word = w_head.pc[31:0];
      3'd1:    w_word = w_head.pc[63:32];
      3'd2:    w_word = w_head.instr;
      3'd3:    w_word = {w_head.seq, 10'b0, w_head.regwrite, w_head.rd};
      3'd4:    w_word = w_head.wdata[31:0];
      3'd5:    w_word = w_head.wdata[63:32];
      default: w_word = '0;
    endcase
  end

  assign out_data = out_valid ? w_word : 32'h0;
  assign out_last = out_valid && (r_idx == LAST_WORD_IDX);

endmodule

// File: tb/tb_riscv_trace_capture.sv
module tb_riscv_trace_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_instr;
  logic [4:0]  commit_rd;
  logic        commit_regwrite;
  logic [63:0] commit_wdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_trace_capture #(
    .DEPTH (8),
    .SEQW  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_instr    (commit_instr),
    .commit_rd       (commit_rd),
    .commit_regwrite (commit_regwrite),
    .commit_wdata    (commit_wdata),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .clear_overflow  (clear_overflow)
  );

  typedef struct {
    logic [63:0]      pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic             rw;
    logic [63:0]      wdata;
    logic [5:0][31:0] w;   // expected words, index k = word k
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Called at a negedge. Waits (bounded) for out_valid with out_ready=1,
  // captures the word, and returns after the accepting edge.
  task automatic get_word(output logic [31:0] d, output logic l, output int n);
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL word_timeout: got out_valid=0 want 1 within 20 cycles");
    end
    d = out_data;
    l = out_last;
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [63:0] pc, input logic [31:0] ins,
                            input logic [4:0] rd, input logic rw, input logic [63:0] wd);
    commit_pc       = pc;
    commit_instr    = ins;
    commit_rd       = rd;
    commit_regwrite = rw;
    commit_wdata    = wd;
  endtask

  // Indexed records used by the multi-record sequences.
  task automatic set_idx(input int i);
    logic [31:0] u;
    u = 32'(i);
    set_fields({u + 32'h100, u * 32'd4}, 32'h13 + u, u[4:0], u[0],
               {32'hF000_0000 + u, 32'h0000_1000 + u});
  endtask

  function automatic logic [31:0] idx_word(input int i, input int seq, input int k);
    logic [31:0] u;
    logic [15:0] s;
    u = 32'(i);
    s = 16'(seq);
    case (k)
      0:       return u * 32'd4;
      1:       return u + 32'h100;
      2:       return 32'h13 + u;
      3:       return {s, 10'b0, u[0], u[4:0]};
      4:       return 32'h0000_1000 + u;
      default: return 32'hF000_0000 + u;
    endcase
  endfunction

  task automatic commit_cycle();
    commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  // Collects nwords of indexed record i; first word must appear after
  // first_n waits (negative: unchecked), later words back to back.
  task automatic expect_idx(input int i, input int seq, input int nwords,
                            input string tag, input int first_n);
    logic [31:0] d;
    logic        l;
    int          n;
    for (int k = 0; k < nwords; k++) begin
      get_word(d, l, n);
      chk($sformatf("%s_w%0d", tag, k), d, idx_word(i, seq, k));
      chk($sformatf("%s_last%0d", tag, k), l, (k == 5));
      if (k > 0) chk($sformatf("%s_gap%0d", tag, k), n, 0);
      else if (first_n >= 0) chk($sformatf("%s_lat", tag), n, first_n);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        l;
    int          n;

    tbl[0] = '{pc: 64'h0000_0000_0000_0010, instr: 32'h00A0_0093, rd: 5'd1, rw: 1'b1,
               wdata: 64'h0000_0000_0000_000A,
               w: {32'h0000_0000, 32'h0000_000A, 32'h0000_0021,
                   32'h00A0_0093, 32'h0000_0000, 32'h0000_0010}};
    tbl[1] = '{pc: 64'h8000_0000_0000_1004, instr: 32'hFFF0_0113, rd: 5'd2, rw: 1'b1,
               wdata: 64'hFFFF_FFFF_FFFF_FFFF,
               w: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0022,
                   32'hFFF0_0113, 32'h8000_0000, 32'h0000_1004}};
    tbl[2] = '{pc: 64'h0000_0001_2345_6788, instr: 32'h0011_2023, rd: 5'd0, rw: 1'b0,
               wdata: 64'h1122_3344_5566_7788,
               w: {32'h1122_3344, 32'h5566_7788, 32'h0002_0000,
                   32'h0011_2023, 32'h0000_0001, 32'h2345_6788}};
    tbl[3] = '{pc: 64'hDEAD_BEEF_CAFE_F00C, instr: 32'h01F0_0FB3, rd: 5'd31, rw: 1'b1,
               wdata: 64'h0123_4567_89AB_CDEF,
               w: {32'h0123_4567, 32'h89AB_CDEF, 32'h0003_003F,
                   32'h01F0_0FB3, 32'hDEAD_BEEF, 32'hCAFE_F00C}};

    reset          = 1'b0;
    commit_valid   = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    set_fields('0, '0, '0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // Table-driven single records with one-cycle latency
    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b1;
      set_fields(tbl[v].pc, tbl[v].instr, tbl[v].rd, tbl[v].rw, tbl[v].wdata);
      commit_cycle();
      chk($sformatf("t%0d_valid_early", v), out_valid, 0);
      for (int k = 0; k < 6; k++) begin
        get_word(d, l, n);
        chk($sformatf("t%0d_w%0d", v, k), d, tbl[v].w[k]);
        chk($sformatf("t%0d_last%0d", v, k), l, (k == 5));
        chk($sformatf("t%0d_wait%0d", v, k), n, (k == 0) ? 1 : 0);
      end
      chk($sformatf("t%0d_idle_after", v), out_valid, 0);
    end

    // Stall at W2 for five cycles; seq is now 4
    set_fields(tbl[0].pc, tbl[0].instr, tbl[0].rd, tbl[0].rw, tbl[0].wdata);
    commit_cycle();
    get_word(d, l, n);
    chk("stall_w0", d, 32'h0000_0010);
    get_word(d, l, n);
    chk("stall_w1", d, 32'h0000_0000);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_hold_valid%0d", c), out_valid, 1);
      chk($sformatf("stall_hold_data%0d", c), out_data, 32'h00A0_0093);
      chk($sformatf("stall_hold_last%0d", c), out_last, 0);
      @(negedge clk);
    end
    get_word(d, l, n);
    chk("stall_w2", d, 32'h00A0_0093);
    get_word(d, l, n);
    chk("stall_w3", d, 32'h0004_0021);
    get_word(d, l, n);
    chk("stall_w4", d, 32'h0000_000A);
    get_word(d, l, n);
    chk("stall_w5", d, 32'h0000_0000);
    chk("stall_w5_last", l, 1);
    chk("stall_idle_after", out_valid, 0);

    // Fresh reset: fill with out_ready=0, ten commits -> 8 kept, 2 dropped
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      set_idx(i);
      commit_valid = 1'b1;
      @(negedge clk);
    end
    commit_valid = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_head_valid", out_valid, 1);

    // Drain record 0; commit record 8 in the cycle W5 is accepted
    expect_idx(0, 0, 5, "full_r0", 0);
    set_idx(8);
    commit_valid = 1'b1;
    get_word(d, l, n);
    commit_valid = 1'b0;
    chk("full_r0_w5", d, idx_word(0, 0, 5));
    chk("full_r0_last5", l, 1);
    chk("full_push_drop", drop_count, 2);
    for (int i = 1; i <= 8; i++) begin
      expect_idx(i, i, 6, $sformatf("drain_r%0d", i), 0);
    end
    chk("drain_idle", out_valid, 0);

    // Refill (seq 9..16), then a drop in the same cycle as a clear
    out_ready = 1'b0;
    for (int i = 20; i < 28; i++) begin
      set_idx(i);
      commit_cycle();
    end
    set_idx(28);
    clear_overflow = 1'b1;
    commit_cycle();
    clear_overflow = 1'b0;
    chk("clr_drop_flag", overflow, 1);
    chk("clr_drop_count", drop_count, 1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_count", drop_count, 0);

    // Reset while W3 of the head record is presented
    expect_idx(20, 9, 3, "rst_mid", 0);
    chk("rst_mid_w3_shown", out_data, idx_word(20, 9, 3));
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_empty", out_valid, 0);
    set_idx(30);
    commit_cycle();
    chk("rst_mid_new_early", out_valid, 0);
    expect_idx(30, 0, 6, "rst_new", 1);
    chk("rst_new_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_trace_capture.md
# riscv_trace_capture

Commit-trace capture block for the 64-bit single-cycle RISC-V core. It sits on the core's observation outputs: PC, instruction, destination register, write-back data and register-write enable. Each committed instruction is buffered in a small FIFO. Records leave as a 32-bit valid/ready word stream, six words per record, toward a host-side dump or checker. Records that arrive while the FIFO is full are dropped and counted; they are never silently lost.

## Interface
- `DEPTH`, default 8: FIFO depth in records; must be a power of 2 and at least 2.
- `SEQW`, default 16: width of the sequence counter and the drop counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `commit_valid`  in  1  a committed instruction is presented this cycle.
- `commit_pc`  in  64  PC of the committed instruction.
- `commit_instr`  in  32  instruction word.
- `commit_rd`  in  5  destination register index.
- `commit_regwrite`  in  1  register file write enable for this instruction.
- `commit_wdata`  in  64  write-back data.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  32  trace word.
- `out_last`  out  1  marks word 5 of a record.
- `out_ready`  in  1  sink accepts the word.
- `overflow`  out  1  sticky flag: at least one record was dropped.
- `drop_count`  out  SEQW  count of dropped records; saturates at all-ones.
- `clear_overflow`  in  1  synchronous clear of `overflow` and `drop_count`.

## Operation
- **Push:**
  - On a rising edge with `commit_valid=1`, if the FIFO is not full, write the record {pc, instr, rd, regwrite, wdata, seq}.
  - `seq` then increments, wrapping at 2^SEQW.
  - `seq` counts accepted records only.
- **Drop:**
  - On a rising edge with `commit_valid=1` and the FIFO full, the record is discarded.
  - `overflow` is set to 1 and `drop_count` increments, saturating.
  - `seq` is unchanged.
- **Word order for the head record:**
  - W0 = pc[31:0]
  - W1 = pc[63:32]
  - W2 = instr
  - W3 = {seq[15:0], 10'b0, regwrite, rd}. When SEQW > 16, only seq[15:0] is sent.
  - W4 = wdata[31:0]
  - W5 = wdata[63:32], with `out_last=1`.
- **Serializer FSM:**
  - States: IDLE, SEND.
  - IDLE → SEND when the FIFO is non-empty; word index = 0.
  - In SEND, a handshake (`out_valid & out_ready`) advances the word index.
  - A handshake on W5 pops the FIFO. The FSM then returns to IDLE if the FIFO becomes empty; otherwise it stays in SEND with index 0.
- **Stability:** while `out_valid=1` and `out_ready=0`, `out_data` and `out_last` hold.
- **Push and pop in the same cycle:**
  - Both take effect.
  - When the FIFO is full and W5 is accepted in that same cycle, the incoming record is accepted, not dropped.
- **Clear:**
  - `clear_overflow=1` zeroes `overflow` and `drop_count`.
  - If a drop happens in the same cycle, the drop wins: `overflow=1`, `drop_count=1`.
- **Reset mid-record:**
  - FIFO emptied, FSM to IDLE, word index 0, `seq` 0.
  - The partial record is abandoned and never resumed.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `overflow=0`, `drop_count=0`.
- Latency: a record pushed at edge N gives `out_valid=1` with W0 after edge N+1. One cycle minimum, from registered FSM state.
- Throughput: one word per cycle when `out_ready=1`, i.e. six cycles per record. Back-to-back records have no idle cycle between W5 and the next W0.
- `out_data`, `out_last` and `out_valid` come from registers or from registered head state plus the word index. No combinational path from `out_ready` to `out_valid` or `out_data`.
- Full and empty are computed from pointers with one extra wrap bit.

## Structure
- Shared package `trace_pkg`:
  - `WORDS_PER_REC = 6`.
  - `trace_rec_t` packed struct: pc, instr, rd, regwrite, wdata, seq.
  - Serializer state enum {IDLE, SEND}.
  - Word-index type (3 bits).
- Sub-module `trace_fifo`:
  - Synchronous FIFO of `trace_rec_t`, DEPTH entries, with push, pop, full, empty.
  - Same `clk` and `reset` as the top.
- Top: push/drop logic, `seq` and drop counters, serializer FSM, word mux.

## Test plan
- Reset, then a single commit {pc=0x0000000000000010, instr=0x00A00093, rd=1, regwrite=1, wdata=0xA}, `out_ready=1` → words 0x00000010, 0x00000000, 0x00A00093, 0x00000021, 0x0000000A, 0x00000000; `out_last` only on the sixth word.
- `out_ready=0` for 5 cycles mid-record (at W2) → W2 held stable; no word lost or duplicated after release.
- `out_ready=0`, 10 consecutive commits with DEPTH=8 → 8 accepted, `overflow=1`, `drop_count=2`; drained records carry seq 0–7.
- FIFO full, commit in the same cycle W5 is accepted → record accepted, `drop_count` unchanged.
- `clear_overflow` in the same cycle as a drop → `overflow=1`, `drop_count=1`. A later clear with no drop → both 0.
- Assert `reset`=0 at W3 of a record, then release → `out_valid=0`, FIFO empty; the next commit is sent with seq=0 starting at W0.
